// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: latches a rectangle request and emits one registered
// pixel per clock in raster order, with solid, stripe and border modes plus clipping.
module rect_fill_engine #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3,
    parameter int MAX_X    = 319,
    parameter int MAX_Y    = 239,
    parameter int LANE_W   = 40
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [COLOUR_W-1:0] alt_colour,
    input  logic [1:0]          mode,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam int XC_W    = X_W + 1;
    localparam int YC_W    = Y_W + 1;
    localparam int LANE_CW = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam logic [XC_W-1:0]    MAX_X_C   = XC_W'(MAX_X);
    localparam logic [YC_W-1:0]    MAX_Y_C   = YC_W'(MAX_Y);
    localparam logic [LANE_CW-1:0] LANE_LAST = LANE_CW'(LANE_W - 1);

    state_t               state_q, state_d;
    logic [XC_W-1:0]      cx_q, cx_d;
    logic [YC_W-1:0]      cy_q, cy_d;
    logic [LANE_CW-1:0]   lane_q, lane_d;
    logic                 odd_q, odd_d;
    logic [X_W-1:0]       x0_q, x0_d, w_q, w_d;
    logic [Y_W-1:0]       y0_q, y0_d, h_q, h_d;
    logic [COLOUR_W-1:0]  col_q, col_d, alt_q, alt_d;
    logic [1:0]           mode_q, mode_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [COLOUR_W-1:0]  colour_q, colour_d;
    logic                 plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [X_W-1:0]       x0_e, w_e;
    logic [Y_W-1:0]       y0_e, h_e;
    logic [COLOUR_W-1:0]  col_e, alt_e;
    logic [1:0]           mode_e;
    logic [XC_W-1:0]      x_first, x_end, nx;
    logic [YC_W-1:0]      y_first, y_end, ny;
    logic [LANE_CW-1:0]   nlane;
    logic                 nodd, do_pixel, visible, on_edge;

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        lane_d   = lane_q;
        odd_d    = odd_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        col_d    = col_q;
        alt_d    = alt_q;
        mode_d   = mode_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        nx       = '0;
        ny       = '0;
        nlane    = '0;
        nodd     = 1'b0;
        do_pixel = 1'b0;
        visible  = 1'b0;
        on_edge  = 1'b0;

        // In IDLE the first pixel is built straight from the request inputs.
        x0_e    = (state_q == IDLE) ? x0         : x0_q;
        y0_e    = (state_q == IDLE) ? y0         : y0_q;
        w_e     = (state_q == IDLE) ? w          : w_q;
        h_e     = (state_q == IDLE) ? h          : h_q;
        col_e   = (state_q == IDLE) ? colour     : col_q;
        alt_e   = (state_q == IDLE) ? alt_colour : alt_q;
        mode_e  = (state_q == IDLE) ? mode       : mode_q;
        x_first = {1'b0, x0_e};
        y_first = {1'b0, y0_e};
        x_end   = x_first + {1'b0, w_e} - XC_W'(1);
        y_end   = y_first + {1'b0, h_e} - YC_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (w != '0 && h != '0) begin
                        state_d  = FILL;
                        x0_d     = x0;
                        y0_d     = y0;
                        w_d      = w;
                        h_d      = h;
                        col_d    = colour;
                        alt_d    = alt_colour;
                        mode_d   = mode;
                        nx       = x_first;
                        ny       = y_first;
                        do_pixel = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cx_q == x_end && cy_q == y_end) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    do_pixel = 1'b1;
                    if (cx_q == x_end) begin
                        nx = x_first;
                        ny = cy_q + YC_W'(1);
                    end else begin
                        nx = cx_q + XC_W'(1);
                        ny = cy_q;
                        // Lane counter wraps instead of dividing the column offset.
                        if (lane_q == LANE_LAST) begin
                            nodd = ~odd_q;
                        end else begin
                            nlane = lane_q + LANE_CW'(1);
                            nodd  = odd_q;
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (do_pixel) begin
            visible  = (nx <= MAX_X_C) && (ny <= MAX_Y_C);
            on_edge  = (nx == x_first) || (nx == x_end) || (ny == y_first) || (ny == y_end);
            cx_d     = nx;
            cy_d     = ny;
            lane_d   = nlane;
            odd_d    = nodd;
            busy_d   = 1'b1;
            x_d      = nx[X_W-1:0];
            y_d      = ny[Y_W-1:0];
            colour_d = (mode_e == 2'd1 && nodd) ? alt_e : col_e;
            plot_d   = visible && ((mode_e != 2'd2) || on_edge);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            lane_q   <= '0;
            odd_q    <= 1'b0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            alt_q    <= '0;
            mode_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            lane_q   <= lane_d;
            odd_q    <= odd_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            alt_q    <= alt_d;
            mode_q   <= mode_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour_out = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: table of directed requests, random
// requests against a loop-based raster model, and abort/reset sequences.
module tb_rect_fill_engine;

    localparam int X_W = 9, Y_W = 8, CW = 3;
    localparam int MAX_X = 319, MAX_Y = 239, LANE_W = 40;

    typedef struct {
        logic [X_W-1:0] x0;
        logic [Y_W-1:0] y0;
        logic [X_W-1:0] w;
        logic [Y_W-1:0] h;
        logic [CW-1:0]  col;
        logic [CW-1:0]  alt;
        logic [1:0]     mode;
        int             exp_cycles;
        int             exp_plots;
    } req_t;

    logic clock = 1'b0;
    logic reset, start, abort;
    logic [X_W-1:0] x0, w, x;
    logic [Y_W-1:0] y0, h, y;
    logic [CW-1:0]  colour, alt_colour, colour_out;
    logic [1:0]     mode;
    logic           plot, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    rect_fill_engine #(
        .X_W(X_W), .Y_W(Y_W), .COLOUR_W(CW),
        .MAX_X(MAX_X), .MAX_Y(MAX_Y), .LANE_W(LANE_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .x0(x0), .y0(y0), .w(w), .h(h),
        .colour(colour), .alt_colour(alt_colour), .mode(mode),
        .x(x), .y(y), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one request and checks every cycle against a nested row/column model.
    task automatic applyStimulus(input req_t rq, input bit noisy, output int cycles, output int plots);
        x0 = rq.x0; y0 = rq.y0; w = rq.w; h = rq.h;
        colour = rq.col; alt_colour = rq.alt; mode = rq.mode;
        start = 1'b1; abort = 1'b0;
        step();
        start = 1'b0;
        cycles = 0;
        plots  = 0;
        if (rq.w == 0 || rq.h == 0) begin
            checkOutput("zero_size_done", {29'd0, busy, done, plot}, 32'b010);
        end else begin
            for (int r = 0; r < int'(rq.h); r++) begin
                for (int c = 0; c < int'(rq.w); c++) begin
                    int col, row;
                    bit vis, cond, odd, ep;
                    logic [CW-1:0] ec;
                    col  = int'(rq.x0) + c;
                    row  = int'(rq.y0) + r;
                    vis  = (col <= MAX_X) && (row <= MAX_Y);
                    cond = (rq.mode != 2'd2) || c == 0 || c == int'(rq.w) - 1 ||
                           r == 0 || r == int'(rq.h) - 1;
                    odd  = ((c / LANE_W) % 2) == 1;
                    ep   = vis && cond;
                    ec   = (rq.mode == 2'd1 && odd) ? rq.alt : rq.col;
                    cycles += int'(busy);
                    plots  += int'(plot);
                    checkOutput("pixel",
                        {9'd0, busy, done, plot, x, y, (plot ? colour_out : 3'd0)},
                        {9'd0, 1'b1, 1'b0, ep, col[X_W-1:0], row[Y_W-1:0], (ep ? ec : 3'd0)});
                    if (noisy) begin
                        start = 1'($urandom_range(0, 1));
                        x0 = X_W'($urandom); y0 = Y_W'($urandom);
                        w = X_W'($urandom); h = Y_W'($urandom);
                        colour = CW'($urandom); mode = 2'($urandom);
                    end
                    step();
                end
            end
            start = 1'b0;
            checkOutput("done_pulse", {29'd0, busy, done, plot}, 32'b010);
        end
        step();
        checkOutput("idle_after", {29'd0, busy, done, plot}, 32'b000);
    endtask

    initial begin
        req_t tbl[9];
        int cyc, plt;
        req_t rq;

        tbl[0] = '{9'd120, 8'd0,   9'd4,   8'd2, 3'd7, 3'd0, 2'd0, 8,   8};
        tbl[1] = '{9'd7,   8'd3,   9'd0,   8'd5, 3'd1, 3'd0, 2'd0, 0,   0};
        tbl[2] = '{9'd0,   8'd0,   9'd100, 8'd1, 3'd1, 3'd2, 2'd1, 100, 100};
        tbl[3] = '{9'd0,   8'd20,  9'd100, 8'd2, 3'd1, 3'd2, 2'd1, 200, 200};
        tbl[4] = '{9'd10,  8'd10,  9'd3,   8'd3, 3'd4, 3'd0, 2'd2, 9,   8};
        tbl[5] = '{9'd318, 8'd0,   9'd4,   8'd1, 3'd6, 3'd0, 2'd0, 4,   2};
        tbl[6] = '{9'd5,   8'd5,   9'd2,   8'd2, 3'd3, 3'd5, 2'd3, 4,   4};
        tbl[7] = '{9'd30,  8'd238, 9'd2,   8'd4, 3'd2, 3'd0, 2'd0, 8,   4};
        tbl[8] = '{9'd0,   8'd0,   9'd1,   8'd1, 3'd5, 3'd0, 2'd2, 1,   1};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; colour = '0; alt_colour = '0; mode = '0;
        #12;
        checkOutput("reset_state", {9'd0, busy, done, plot, x, y, colour_out}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i], 1'b0, cyc, plt);
            checkOutput($sformatf("tbl%0d_cycles", i), cyc, tbl[i].exp_cycles);
            checkOutput($sformatf("tbl%0d_plots", i), plt, tbl[i].exp_plots);
        end

        // Abort while the fifth pixel is on the outputs.
        x0 = 9'd50; y0 = 8'd50; w = 9'd10; h = 8'd10; colour = 3'd5; mode = 2'd0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("abort_run", {22'd0, busy, plot, x}, {22'd0, 1'b1, 1'b1, 9'(50 + i)});
            if (i == 4) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        checkOutput("abort_idle", {29'd0, busy, done, plot}, 32'd0);
        repeat (3) begin
            step();
            checkOutput("abort_no_done", {29'd0, busy, done, plot}, 32'd0);
        end
        applyStimulus(tbl[0], 1'b0, cyc, plt);
        checkOutput("after_abort_cycles", cyc, 8);

        // Abort on the very last pixel suppresses done.
        x0 = 9'd2; y0 = 8'd2; w = 9'd2; h = 8'd1; mode = 2'd0;
        start = 1'b1; step(); start = 1'b0;
        step();
        checkOutput("last_pixel_x", {22'd0, busy, plot, x}, {22'd0, 1'b1, 1'b1, 9'd3});
        abort = 1'b1; step(); abort = 1'b0;
        checkOutput("abort_last", {29'd0, busy, done, plot}, 32'd0);
        step();
        checkOutput("abort_last_no_done", {29'd0, busy, done, plot}, 32'd0);

        // Abort has no effect on the DONE cycle of a zero-size request.
        w = 9'd0; h = 8'd3; start = 1'b1; abort = 1'b1; step(); start = 1'b0;
        checkOutput("abort_in_done", {29'd0, busy, done, plot}, 32'b010);
        abort = 1'b0; step();

        // Asynchronous reset mid-fill clears outputs without waiting for a clock.
        x0 = 9'd60; y0 = 8'd60; w = 9'd10; h = 8'd10; colour = 3'd7;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        #2 reset = 1'b1;
        #1 checkOutput("async_reset", {9'd0, busy, done, plot, x, y, colour_out}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        step();
        checkOutput("reset_no_done", {29'd0, busy, done, plot}, 32'd0);

        // Random requests with start and request fields toggled during FILL.
        for (int i = 0; i < 25; i++) begin
            rq.x0   = (i % 3 == 0) ? X_W'($urandom_range(300, 511)) : X_W'($urandom_range(0, 320));
            rq.y0   = (i % 4 == 0) ? Y_W'($urandom_range(230, 255)) : Y_W'($urandom_range(0, 240));
            rq.w    = X_W'($urandom_range(0, 100));
            rq.h    = Y_W'($urandom_range(0, 4));
            rq.col  = CW'($urandom);
            rq.alt  = CW'($urandom);
            rq.mode = 2'($urandom);
            applyStimulus(rq, 1'b1, cyc, plt);
            checkOutput("rand_cycles", cyc, int'(rq.w) * int'(rq.h));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
Parametrised rectangle fill engine for the VGA adapter pixel port. On a start request it latches a rectangle origin, size, colour pair and fill mode, then emits one registered pixel per clock in raster order. Modes are solid, lane stripes and border only. It replaces the fixed-size clear-screen sweeper and adds a start/busy/done handshake, abort, and clipping at the screen edge. Piano-tile drawing and screen clearing both issue requests to it.

Parameters:
X_W, 9, width of x coordinate and width field
Y_W, 8, width of y coordinate and height field
COLOUR_W, 3, colour width
MAX_X, 319, last visible column; pixels with x > MAX_X are not plotted
MAX_Y, 239, last visible row; pixels with y > MAX_Y are not plotted
LANE_W, 40, stripe width in columns for stripe mode (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
abort  in  1  cancel current fill
x0  in  X_W  rectangle left column
y0  in  Y_W  rectangle top row
w  in  X_W  width in pixels
h  in  Y_W  height in pixels
colour  in  COLOUR_W  primary colour
alt_colour  in  COLOUR_W  secondary colour (stripe mode)
mode  in  2  0 solid, 1 stripe, 2 border, 3 treated as solid
x  out  X_W  pixel column
y  out  Y_W  pixel row
colour_out  out  COLOUR_W  pixel colour
plot  out  1  pixel write enable
busy  out  1  high from the cycle after start is accepted through the last pixel
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asynchronous assertion forces state IDLE, x=0, y=0, colour_out=0, plot=0, busy=0, done=0, and clears all latched fields. Reset asserted mid-fill abandons the fill with no done pulse.
- All outputs are registered.
- States:
  - IDLE: done=0 except the pulse cycle. On start=1 with w!=0 and h!=0: latch x0, y0, w, h, colour, alt_colour and mode, then go to FILL. On start=1 with w==0 or h==0: go to DONE, with no plot.
  - FILL: one position per cycle. The first position, (x0,y0), is presented the cycle after start is sampled. Column advances each cycle. At column x0+w-1 the column wraps to x0 and the row increments. Total FILL cycles = w*h.
  - DONE: single cycle; done=1, busy=0, plot=0; then IDLE.
- busy=1 in every FILL cycle; otherwise 0.
- start while busy is ignored and not queued.
- Internal position counters are X_W+1 and Y_W+1 bits, so x0+w-1 and y0+h-1 do not wrap.
- Clipping: a position with column > MAX_X or row > MAX_Y is traversed with plot=0. Ports x and y carry the low X_W and Y_W bits.
- plot=1 in FILL only when the position is visible and the mode condition holds:
  - solid: always; colour_out = colour.
  - stripe: always. A lane counter restarts at each row start and each time it reaches LANE_W-1; lane parity toggles on each restart within a row. Even lanes use colour, odd lanes use alt_colour. No divider is used.
  - border: only when column is x0 or x0+w-1, or row is y0 or y0+h-1; colour_out = colour. Interior positions give plot=0.
- Abort: in FILL, abort=1 returns to IDLE next cycle with plot=0, busy=0 and no done. Abort in IDLE or DONE has no effect. If abort and the last pixel coincide, abort wins and there is no done.
- After the last FILL cycle, the next cycle is DONE.

Test Plan:
- Solid fill, x0=120, y0=0, w=4, h=2, colour=3'b111, mode=0 -> 8 consecutive plot cycles at (120..123, 0) then (120..123, 1), all colour 7; busy high for those 8 cycles; done pulse on cycle 9; then IDLE.
- Zero size, start with w=0, h=5 -> no plot; done pulse the cycle after start; busy stays 0.
- Stripe mode, x0=0, w=100, h=1, LANE_W=40, colour=1, alt_colour=2 -> columns 0-39 carry 1, 40-79 carry 2, 80-99 carry 1; lane pattern restarts at each row for h=2.
- Border mode, x0=10, y0=10, w=3, h=3 -> 9 FILL cycles; plot=0 only at (11,11); the other 8 positions are plotted.
- Clipping, x0=318, w=4, h=1, MAX_X=319 -> plot on columns 318 and 319 only; 4 FILL cycles; done pulse.
- Abort and reset:
  - abort at the 5th pixel of a 10x10 fill -> next cycle IDLE, plot=0, no done; a new start is accepted next.
  - asynchronous reset mid-fill -> all outputs 0 immediately.
  - start asserted during FILL is ignored.
